mor1kx_dbus_sram_responder: RTL

Data-bus responder (slave end) for the espresso LSU dbus request/ack protocol, backed by a word-addressed synchronous SRAM array. It accepts single accesses (req/we/bsel/adr/dat), inserts a programmable number of wait states, and returns one-cycle ack (or err) with big-endian read data. It is used as tightly-coupled data memory and as the bench-side memory model for LSU verification.

---
 rtl/mor1kx_dbus_sram_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mor1kx_dbus_sram_responder.sv
// Espresso LSU dbus slave over a word-addressed synchronous SRAM with programmable wait states.
// Optional MOR1KX_DBUS_RESPONDER_STALL_EN adds 0..3 LFSR-driven extra wait cycles per access.
module mor1kx_dbus_sram_responder #(
  parameter int          OPTION_OPERAND_WIDTH = 32,
  parameter int          MEM_ADDR_WIDTH       = 10,
  parameter logic [31:0] BASE_ADDR            = 32'h0000_0000,
  parameter int          WAIT_STATES          = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
  input  logic                            dbus_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
  input  logic [3:0]                      dbus_bsel_i,
  input  logic                            dbus_we_i,
  input  logic                            dbus_burst_i,
  output logic                            dbus_ack_o,
  output logic                            dbus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o
);

  localparam int          AW       = OPTION_OPERAND_WIDTH;
  localparam int          HI       = MEM_ADDR_WIDTH + 2;
  localparam int          DEPTH    = 1 << MEM_ADDR_WIDTH;
  localparam logic [4:0]  WAIT_CNT = 5'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [4:0]        cnt_reg, cnt_next;
  logic [4:0]        load_cnt;
  logic              accept, commit;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;
  logic              rd_valid_reg, rd_valid_next;

  logic [AW-1:0]     adr_reg, dat_reg;
  logic [3:0]        bsel_reg;
  logic              we_reg;

  logic [AW-1:0]     c_adr, c_dat;
  logic [3:0]        c_bsel;
  logic              c_we, c_err, adr_hit;
  logic              mem_we, mem_re;
  logic [MEM_ADDR_WIDTH-1:0] mem_idx;
  logic [AW-1:0]     rd_data;
  logic              unused_ok;

`ifdef MOR1KX_DBUS_RESPONDER_STALL_EN
  logic [7:0] lfsr_reg;

  // Taps 8,6,5,4; the pre-advance low bits set the stall for the access being accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr_reg <= 8'hA5;
    else if (accept)
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  assign load_cnt = WAIT_CNT + {3'b000, lfsr_reg[1:0]};
`else
  assign load_cnt = WAIT_CNT;
`endif

  // With zero wait states the commit happens on the accept edge, so use the live bus.
  assign c_adr  = (state_reg == IDLE) ? dbus_adr_i  : adr_reg;
  assign c_dat  = (state_reg == IDLE) ? dbus_dat_i  : dat_reg;
  assign c_bsel = (state_reg == IDLE) ? dbus_bsel_i : bsel_reg;
  assign c_we   = (state_reg == IDLE) ? dbus_we_i   : we_reg;

  assign adr_hit = (c_adr[AW-1:HI] == BASE_ADDR[AW-1:HI]);
  assign c_err   = !adr_hit || (c_bsel == 4'b0000);
  assign mem_idx = c_adr[HI-1:2];
  assign mem_we  = commit && !c_err && c_we && !rst;
  assign mem_re  = commit && !c_err && !c_we;

  assign unused_ok = ^{dbus_burst_i, c_adr[1:0]};

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    accept        = 1'b0;
    commit        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dbus_req_i) begin
          accept   = 1'b1;
          cnt_next = load_cnt;
          if (load_cnt == 5'd0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!dbus_req_i) begin
          state_next = IDLE;
          cnt_next   = 5'd0;
        end else if (cnt_reg == 5'd1) begin
          commit     = 1'b1;
          state_next = RESP;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      RESP:    state_next = HOLD;
      default: state_next = IDLE;
    endcase
    ack_next      = commit && !c_err;
    err_next      = commit && c_err;
    rd_valid_next = mem_re;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      adr_reg  <= dbus_adr_i;
      dat_reg  <= dbus_dat_i;
      bsel_reg <= dbus_bsel_i;
      we_reg   <= dbus_we_i;
    end
  end

  // One byte-wide RAM per lane; lane gi holds bits gi*8+7:gi*8 (bsel bit3 = MSB byte).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte;

      always_ff @(posedge clk) begin
        if (mem_we && c_bsel[gi])
          mem[mem_idx] <= c_dat[gi*8 +: 8];
        if (mem_re)
          rd_byte <= mem[mem_idx];
      end

      assign rd_data[gi*8 +: 8] = rd_byte;
    end
  endgenerate

  assign dbus_ack_o = ack_reg;
  assign dbus_err_o = err_reg;
  assign dbus_dat_o = rd_valid_reg ? rd_data : '0;

endmodule
